// File: rtl/cond_incr_scheduler_pkg.sv
// Shared types for the conditional-increment scheduler: op encoding, compare codes, FSM states.
package ci_sched_pkg;

  localparam int CI_ADDR_W = 5;
  localparam int CI_NFLAG  = 8;
  localparam int CI_FLAG_W = $clog2(CI_NFLAG + 1);

  // Flag select equal to the flag count means "always true" for cond_flag and "no write" for set_flag.
  localparam logic [CI_FLAG_W-1:0] FLAG_ALWAYS = CI_FLAG_W'(CI_NFLAG);

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_e;

  typedef struct packed {
    logic        is_addr;
    logic [31:0] value;
  } ci_operand_t;

  typedef struct packed {
    logic [CI_ADDR_W-1:0] target;
    cmp_op_e              cmp_op;
    ci_operand_t          cmp;
    ci_operand_t          inc;
    logic [CI_FLAG_W-1:0] set_flag;
    logic [CI_FLAG_W-1:0] cond_flag;
  } ci_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_T = 3'd1,
    S_RD_C = 3'd2,
    S_RD_I = 3'd3,
    S_EXEC = 3'd4,
    S_RESP = 3'd5
  } ci_state_e;

  // Which operand register the read data arriving this cycle belongs to.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_T    = 2'd1,
    PEND_C    = 2'd2,
    PEND_I    = 2'd3
  } ci_pend_e;

  function automatic logic ci_compare(input cmp_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      CMP_EQ:  return sa == sb;
      CMP_NE:  return sa != sb;
      CMP_LT:  return sa <  sb;
      CMP_LE:  return sa <= sb;
      CMP_GT:  return sa >  sb;
      CMP_GE:  return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_incr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at/after the pointer; pointer moves past it on advance.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned k;
    logic        found;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr_q) + i) % NREQ;
      if (!found && req[PTR_W'(k)]) begin
        found             = 1'b1;
        grant[PTR_W'(k)]  = 1'b1;
        if (advance) ptr_d = PTR_W'((k + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cond_incr_scheduler.sv
// Shared conditional-increment engine sequencing ops against the u32 regfile and flag bank.
// Define CI_SCHED_SAT_EN for signed-saturating increment; default build wraps modulo 2^32.
module cond_incr_scheduler
  import ci_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = CI_ADDR_W,
  parameter int NFLAG  = CI_NFLAG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  ci_op_t [NREQ-1:0]          req_op,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       rsp_taken,
  output logic                       rf_rd_en,
  output logic [ADDR_W-1:0]          rf_rd_addr,
  input  logic [31:0]                rf_rd_data,
  output logic                       rf_wr_en,
  output logic [ADDR_W-1:0]          rf_wr_addr,
  output logic [31:0]                rf_wr_data,
  input  logic [NFLAG-1:0]           flags_i,
  output logic                       flag_we,
  output logic [$clog2(NFLAG+1)-1:0] flag_idx,
  output logic                       flag_val
);

  localparam int ID_W = $clog2(NREQ);
  localparam int FI_W = (NFLAG > 1) ? $clog2(NFLAG) : 1;

  ci_state_e          state_q, state_d;
  ci_pend_e           pend_q, pend_d;
  ci_op_t             op_q, op_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        tgt_q, tgt_d, cmp_q, cmp_d, inc_q, inc_d;
  logic               taken_q, taken_d;

  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    gnt_idx;
  ci_op_t             gnt_op;
  logic               advance, cond_ok;
  logic [31:0]        tgt_v, cmp_v, inc_v, sum_wrap, wr_data;
  logic               cmp_res;
  logic               unused_op;

  assign advance = (state_q == S_IDLE) && (|req_valid);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = ID_W'(i);
    end
  end

  assign gnt_op  = req_op[gnt_idx];
  assign cond_ok = !(int'(gnt_op.cond_flag) < NFLAG) || flags_i[gnt_op.cond_flag[FI_W-1:0]];

  // Read data lands one cycle after its strobe; use it directly that cycle, register it for later.
  assign tgt_v = (pend_q == PEND_T) ? rf_rd_data : tgt_q;
  assign cmp_v = (pend_q == PEND_C) ? rf_rd_data : cmp_q;
  assign inc_v = (pend_q == PEND_I) ? rf_rd_data : inc_q;

  assign cmp_res  = ci_compare(op_q.cmp_op, tgt_v, cmp_v);
  assign sum_wrap = tgt_v + inc_v;

`ifdef CI_SCHED_SAT_EN
  always_comb begin
    wr_data = sum_wrap;
    if ((tgt_v[31] == inc_v[31]) && (sum_wrap[31] != tgt_v[31]))
      wr_data = tgt_v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end
`else
  assign wr_data = sum_wrap;
`endif

  // Operand addresses are taken from cmp_q/inc_q, so the latched op values are otherwise unused.
  assign unused_op = ^{op_q.cmp.value, op_q.inc.value, op_q.cond_flag};

  always_comb begin
    state_d    = state_q;
    pend_d     = PEND_NONE;
    op_d       = op_q;
    id_d       = id_q;
    tgt_d      = tgt_v;
    cmp_d      = cmp_v;
    inc_d      = inc_v;
    taken_d    = taken_q;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_taken  = 1'b0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    flag_we    = 1'b0;
    flag_idx   = '0;
    flag_val   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          op_d      = gnt_op;
          id_d      = gnt_idx;
          tgt_d     = '0;
          cmp_d     = gnt_op.cmp.value;
          inc_d     = gnt_op.inc.value;
          taken_d   = 1'b0;
          state_d   = cond_ok ? S_RD_T : S_RESP;
        end
      end
      S_RD_T: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = op_q.target;
        pend_d     = PEND_T;
        state_d    = op_q.cmp.is_addr ? S_RD_C : (op_q.inc.is_addr ? S_RD_I : S_EXEC);
      end
      S_RD_C: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = cmp_q[ADDR_W-1:0];
        pend_d     = PEND_C;
        state_d    = op_q.inc.is_addr ? S_RD_I : S_EXEC;
      end
      S_RD_I: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = inc_q[ADDR_W-1:0];
        pend_d     = PEND_I;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        taken_d = cmp_res;
        if (int'(op_q.set_flag) < NFLAG) begin
          flag_we  = 1'b1;
          flag_idx = op_q.set_flag;
          flag_val = cmp_res;
        end
        if (cmp_res) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = op_q.target;
          rf_wr_data = wr_data;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_taken = taken_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= PEND_NONE;
      op_q    <= '0;
      id_q    <= '0;
      tgt_q   <= '0;
      cmp_q   <= '0;
      inc_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      id_q    <= id_d;
      tgt_q   <= tgt_d;
      cmp_q   <= cmp_d;
      inc_q   <= inc_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_cond_incr_scheduler.sv
// Directed self-checking bench for cond_incr_scheduler with a behavioural regfile.
module tb_cond_incr_scheduler;
  import ci_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid, req_ready;
  ci_op_t [3:0]     req_op;
  logic             rsp_valid, rsp_taken;
  logic [1:0]       rsp_id;
  logic             rf_rd_en, rf_wr_en, flag_we, flag_val;
  logic [4:0]       rf_rd_addr, rf_wr_addr;
  logic [31:0]      rf_rd_data, rf_wr_data;
  logic [7:0]       flags_i;
  logic [3:0]       flag_idx;

  logic [31:0]      mem [32];
  logic             tb_we;
  logic [4:0]       tb_wa;
  logic [31:0]      tb_wd;

  int checks = 0, errors = 0;
  int cyc = 0, rsp_cnt = 0, rd_cnt = 0, wr_cnt = 0, flag_cnt = 0;
  int gnt_cyc = 0, rsp_cyc = 0, wr_cyc = 0, flag_cyc = 0, rsp_id_l = 0, flag_idx_l = 0;
  logic rsp_taken_l = 1'b0, flag_val_l = 1'b0;
  int gnt_q[$];
  int lat, rid, rd0, wr0, fl0, r0, g0;
  logic tk;
  bit ok;

  cond_incr_scheduler #(.NREQ(4), .ADDR_W(5), .NFLAG(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_taken(rsp_taken),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .flags_i(flags_i), .flag_we(flag_we), .flag_idx(flag_idx), .flag_val(flag_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  always @(negedge clk) begin
    cyc++;
    if (|req_ready) begin
      for (int i = 0; i < 4; i++) if (req_ready[i]) gnt_q.push_back(i);
      gnt_cyc = cyc;
    end
    if (rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_id_l = int'(rsp_id); rsp_taken_l = rsp_taken;
    end
    if (rf_rd_en) rd_cnt++;
    if (rf_wr_en) begin wr_cnt++; wr_cyc = cyc; end
    if (flag_we) begin
      flag_cnt++; flag_cyc = cyc; flag_idx_l = int'(flag_idx); flag_val_l = flag_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ci_op_t mk(input logic [4:0] t, input cmp_op_e c, input logic ca,
                                input logic [31:0] cv, input logic ia, input logic [31:0] iv,
                                input logic [3:0] sf, input logic [3:0] cf);
    ci_op_t o;
    o.target = t; o.cmp_op = c; o.cmp.is_addr = ca; o.cmp.value = cv;
    o.inc.is_addr = ia; o.inc.value = iv; o.set_flag = sf; o.cond_flag = cf;
    return o;
  endfunction

  task automatic rf_set(input logic [4:0] a, input logic [31:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(posedge clk); #1 tb_we = 1'b0;
  endtask

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; fl0 = flag_cnt; r0 = rsp_cnt; g0 = gnt_q.size();
  endtask

  task automatic wait_grant(input string tag);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (gnt_q.size() != g0) begin ok = 1'b1; break; end
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] id, input ci_op_t op);
    snap();
    req_op[id] = op; req_valid[id] = 1'b1;
    wait_grant("grant_wait");
    #1 req_valid[id] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_cnt != r0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    check("rsp_wait", {31'b0, ok}, 32'd1);
    #1;
    lat = rsp_cyc - gnt_cyc; tk = rsp_taken_l; rid = rsp_id_l;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; flags_i = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'b0, req_ready, rsp_valid}, 32'd0);
    check("reset_strobes", {29'b0, rf_rd_en, rf_wr_en, flag_we}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Immediate compare true, 3-cycle latency
    rf_set(5'd3, 32'd5);
    run_op(2'd0, mk(5'd3, CMP_GT, 1'b0, 32'd4, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t1_r3", mem[3], 32'd6);
    check("t1_taken", {31'b0, tk}, 32'd1);
    check("t1_id", rid, 32'd0);
    check("t1_lat", lat, 32'd3);
    check("t1_rd_wr_fl", {(rd_cnt - rd0), (wr_cnt - wr0), (flag_cnt - fl0)} == {32'd1, 32'd1, 32'd0}, 32'd1);

    // Compare false with flag write
    rf_set(5'd3, 32'd2);
    run_op(2'd0, mk(5'd3, CMP_GT, 1'b0, 32'd4, 1'b0, 32'd1, 4'd1, FLAG_ALWAYS));
    check("t2_r3", mem[3], 32'd2);
    check("t2_wr", wr_cnt - wr0, 32'd0);
    check("t2_flag_cnt", flag_cnt - fl0, 32'd1);
    check("t2_flag_idx", flag_idx_l, 32'd1);
    check("t2_flag_val", {31'b0, flag_val_l}, 32'd0);
    check("t2_taken", {31'b0, tk}, 32'd0);

    // Condition flag clear: straight to response, nothing touched
    flags_i = 8'hFB;
    run_op(2'd0, mk(5'd3, CMP_GT, 1'b0, 32'd0, 1'b0, 32'd1, 4'd1, 4'd2));
    check("t3_rd", rd_cnt - rd0, 32'd0);
    check("t3_wr", wr_cnt - wr0, 32'd0);
    check("t3_flag", flag_cnt - fl0, 32'd0);
    check("t3_taken", {31'b0, tk}, 32'd0);
    check("t3_lat", lat, 32'd1);
    flags_i = 8'h04;
    run_op(2'd0, mk(5'd3, CMP_GT, 1'b0, 32'd0, 1'b0, 32'd1, FLAG_ALWAYS, 4'd2));
    check("t3b_r3", mem[3], 32'd3);
    check("t3b_taken", {31'b0, tk}, 32'd1);

    // Address operands, inc aliases target (reads pre-write value)
    rf_set(5'd3, 32'd20);
    rf_set(5'd4, 32'd10);
    run_op(2'd0, mk(5'd3, CMP_GT, 1'b1, 32'd4, 1'b1, 32'd3, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t5_r3", mem[3], 32'd40);
    check("t5_lat", lat, 32'd5);
    check("t5_rd", rd_cnt - rd0, 32'd3);

    // Overflow both directions
    rf_set(5'd7, 32'h7FFF_FFFF);
    rf_set(5'd8, 32'h8000_0000);
    run_op(2'd1, mk(5'd7, CMP_GE, 1'b0, 32'd0, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t6_id", rid, 32'd1);
    run_op(2'd1, mk(5'd8, CMP_LT, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFF, FLAG_ALWAYS, FLAG_ALWAYS));
`ifdef CI_SCHED_SAT_EN
    check("t6_pos_ovf", mem[7], 32'h7FFF_FFFF);
    check("t6_neg_ovf", mem[8], 32'h8000_0000);
`else
    check("t6_pos_ovf", mem[7], 32'h8000_0000);
    check("t6_neg_ovf", mem[8], 32'h7FFF_FFFF);
`endif

    // Signed compares and unknown code
    rf_set(5'd9, 32'hFFFF_FFFF);
    run_op(2'd2, mk(5'd9, CMP_LT, 1'b0, 32'd1, 1'b0, 32'd2, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t7_lt_signed", mem[9], 32'd1);
    run_op(2'd2, mk(5'd9, cmp_op_e'(3'd7), 1'b0, 32'd1, 1'b0, 32'd5, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t7_unknown_taken", {31'b0, tk}, 32'd0);
    check("t7_unknown_r9", mem[9], 32'd1);
    run_op(2'd2, mk(5'd9, CMP_LE, 1'b0, 32'd1, 1'b0, 32'h10, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t7_le", mem[9], 32'h11);
    run_op(2'd2, mk(5'd9, CMP_NE, 1'b0, 32'h11, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t7_ne_false", {31'b0, tk}, 32'd0);
    run_op(2'd2, mk(5'd9, CMP_EQ, 1'b0, 32'h11, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS));
    check("t7_eq", mem[9], 32'h12);

    // Flag and regfile written in the same cycle
    rf_set(5'd15, 32'd0);
    run_op(2'd3, mk(5'd15, CMP_EQ, 1'b0, 32'd0, 1'b0, 32'd3, 4'd5, FLAG_ALWAYS));
    check("t10_r15", mem[15], 32'd3);
    check("t10_same_cycle", flag_cyc - wr_cyc, 32'd0);
    check("t10_flag", {flag_idx_l[27:0], 3'b0, flag_val_l}, {28'd5, 4'd1});
    check("t10_id", rid, 32'd3);

    // Requester drops valid while engine is busy: never granted
    rf_set(5'd16, 32'd1);
    rf_set(5'd20, 32'd0);
    snap();
    req_op[0] = mk(5'd16, CMP_LT, 1'b1, 32'd4, 1'b1, 32'd4, FLAG_ALWAYS, FLAG_ALWAYS);
    req_valid[0] = 1'b1;
    wait_grant("t8_grant_wait");
    #1 req_valid[0] = 1'b0;
    req_op[1] = mk(5'd20, CMP_EQ, 1'b0, 32'd0, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS);
    req_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t8_grants", gnt_q.size() - g0, 32'd1);
    check("t8_rsps", rsp_cnt - r0, 32'd1);
    check("t8_r16", mem[16], 32'd11);
    check("t8_r20", mem[20], 32'd0);

    // Reset in the middle of an op aborts it
    rf_set(5'd17, 32'd5);
    snap();
    req_op[0] = mk(5'd17, CMP_LT, 1'b1, 32'd4, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS);
    req_valid[0] = 1'b1;
    wait_grant("t9_grant_wait");
    #1 req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t9_r17", mem[17], 32'd5);
    check("t9_wr", wr_cnt - wr0, 32'd0);
    check("t9_rsp", rsp_cnt - r0, 32'd0);

    // All requesters continuously valid from a fresh pointer
    for (int i = 0; i < 4; i++) rf_set(5'(10 + i), 32'd0);
    for (int i = 0; i < 4; i++)
      req_op[i] = mk(5'(10 + i), CMP_GE, 1'b0, 32'h8000_0000, 1'b0, 32'd1, FLAG_ALWAYS, FLAG_ALWAYS);
    snap();
    req_valid = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (gnt_q.size() >= g0 + 5) begin ok = 1'b1; break; end
    end
    #1 req_valid = '0;
    check("t4_grant_wait", {31'b0, ok}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    if (ok) begin
      check("t4_g0", gnt_q[g0], 32'd0);
      check("t4_g1", gnt_q[g0 + 1], 32'd1);
      check("t4_g2", gnt_q[g0 + 2], 32'd2);
      check("t4_g3", gnt_q[g0 + 3], 32'd3);
      check("t4_g4", gnt_q[g0 + 4], 32'd0);
    end
    check("t4_r10", mem[10], 32'd2);
    check("t4_r11", mem[11], 32'd1);
    check("t4_r12", mem[12], 32'd1);
    check("t4_r13", mem[13], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
